mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 153 +++++++++++++++
 rtl/mc_controller_decode.sv | 43 ++++
 rtl/mc_controller.sv | 103 ++++++++++
 tb/tb_mc_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, ALU codes,
// FSM states, instruction classes and the per-state control bundle.
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_EQ  = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_REG    = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_ADDU, CL_SUBU, CL_SLL, CL_JR, CL_JALR, CL_ORI,
    CL_LUI, CL_LW, CL_LB, CL_SW, CL_BEQ, CL_J, CL_JAL
  } instClass_t;

  typedef struct packed {
    logic       pcWe;
    logic       irWe;
    logic       regWe;
    logic       memWe;
    logic       memRe;
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       extOp;
    logic [1:0] regDst;
    logic [1:0] wdSel;
    logic [1:0] npcSel;
    logic       lbSel;
    logic       branch;
  } ctrl_t;

  // Control word for a given state and latched class. ALU controls stay stable
  // through MEM and WB so the address and result do not move under the access.
  function automatic ctrl_t ctrlFor(state_t s, instClass_t c);
    ctrl_t k;
    logic  isLoad;
    logic  isRtype;
    k       = '0;
    isLoad  = (c == CL_LW) || (c == CL_LB);
    isRtype = (c == CL_ADDU) || (c == CL_SUBU) || (c == CL_SLL);
    case (s)
      ST_FETCH: begin
        k.irWe   = 1'b1;
        k.pcWe   = 1'b1;
        k.npcSel = NPC_SEQ;
      end
      ST_EXEC, ST_MEM, ST_WB: begin
        case (c)
          CL_ADDU: k.aluOp = ALU_ADD;
          CL_SUBU: k.aluOp = ALU_SUB;
          CL_SLL:  k.aluOp = ALU_SLL;
          CL_ORI: begin
            k.aluOp  = ALU_OR;
            k.aluSrc = 1'b1;
          end
          CL_LUI: begin
            k.aluOp  = ALU_LUI;
            k.aluSrc = 1'b1;
          end
          CL_LW, CL_LB, CL_SW: begin
            k.aluOp  = ALU_ADD;
            k.aluSrc = 1'b1;
            k.extOp  = 1'b1;
          end
          CL_BEQ:  k.aluOp = ALU_EQ;
          default: ;
        endcase
        if (s == ST_EXEC) begin
          case (c)
            CL_BEQ: begin
              k.branch = 1'b1;
              k.npcSel = NPC_BRANCH;
            end
            CL_J: begin
              k.pcWe   = 1'b1;
              k.npcSel = NPC_JUMP;
            end
            CL_JAL: begin
              k.pcWe   = 1'b1;
              k.npcSel = NPC_JUMP;
              k.regWe  = 1'b1;
              k.regDst = DST_RA;
              k.wdSel  = WD_PC4;
            end
            CL_JR: begin
              k.pcWe   = 1'b1;
              k.npcSel = NPC_REG;
            end
            CL_JALR: begin
              k.pcWe   = 1'b1;
              k.npcSel = NPC_REG;
              k.regWe  = 1'b1;
              k.regDst = DST_RD;
              k.wdSel  = WD_PC4;
            end
            default: ;
          endcase
        end
        if (s == ST_MEM) begin
          k.memWe = (c == CL_SW);
          k.memRe = isLoad;
        end
        if (s == ST_WB) begin
          k.regWe  = 1'b1;
          k.regDst = isRtype ? DST_RD : DST_RT;
          k.wdSel  = isLoad ? WD_MEM : WD_ALU;
          k.lbSel  = (c == CL_LB);
        end
      end
      default: ;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mc_controller_decode.sv
// Combinational instruction classifier: maps op/func to an instruction class,
// with the optional sll/jalr/lb group removable at elaboration.
module mc_decode
  import mc_controller_pkg::*;
#(
  parameter int EXT_EN = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output instClass_t cls,
  output logic       illegal
);

  localparam logic extOn = (EXT_EN != 0);

  always_comb begin
    cls = CL_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: cls = CL_ADDU;
          FN_SUBU: cls = CL_SUBU;
          FN_SLL:  if (extOn) cls = CL_SLL;
          FN_JR:   cls = CL_JR;
          FN_JALR: if (extOn) cls = CL_JALR;
          default: ;
        endcase
      end
      OP_ORI:  cls = CL_ORI;
      OP_LUI:  cls = CL_LUI;
      OP_LW:   cls = CL_LW;
      OP_LB:   if (extOn) cls = CL_LB;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: ;
    endcase
  end

  assign illegal = (cls == CL_ILLEGAL);

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller FSM (FETCH/DECODE/EXEC/MEM/WB). The control word is
// registered alongside the state; reset forces every output low immediately.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int EXT_EN      = 1,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic               mem_we,
  output logic               mem_re,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               ext_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wd_sel,
  output logic [1:0]         npc_sel,
  output logic               lb_sel,
  output logic               illegal,
  output logic [2:0]         state
);

  state_t     stateQ, stateD;
  instClass_t clsQ, clsD, decCls;
  ctrl_t      ctrlQ;
  logic       decIll;
  logic       memReady;
  logic       outOn;

  mc_decode #(.EXT_EN(EXT_EN)) uDecode (
    .op      (op),
    .func    (func),
    .cls     (decCls),
    .illegal (decIll)
  );

  assign memReady = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_comb begin
    stateD = ST_FETCH;
    clsD   = clsQ;
    case (stateQ)
      ST_FETCH: stateD = ST_DECODE;
      ST_DECODE: begin
        clsD   = decCls;
        stateD = decIll ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: begin
        case (clsQ)
          CL_LW, CL_LB, CL_SW:                    stateD = ST_MEM;
          CL_ADDU, CL_SUBU, CL_SLL, CL_ORI, CL_LUI: stateD = ST_WB;
          default:                                stateD = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!memReady)          stateD = ST_MEM;
        else if (clsQ == CL_SW) stateD = ST_FETCH;
        else                    stateD = ST_WB;
      end
      default: stateD = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= ST_FETCH;
      clsQ   <= CL_ILLEGAL;
      ctrlQ  <= ctrlFor(ST_FETCH, CL_ILLEGAL);
    end else begin
      stateQ <= stateD;
      clsQ   <= clsD;
      ctrlQ  <= ctrlFor(stateD, clsD);
    end
  end

  // Reset and unused state encodings silence every output combinationally.
  assign outOn = !reset && (stateQ inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB});

  assign pc_we   = outOn & (ctrlQ.pcWe | (ctrlQ.branch & zero));
  assign ir_we   = outOn & ctrlQ.irWe;
  assign reg_we  = outOn & ctrlQ.regWe;
  assign mem_we  = outOn & ctrlQ.memWe;
  assign mem_re  = outOn & ctrlQ.memRe;
  assign alu_op  = outOn ? ALUOP_W'(ctrlQ.aluOp) : '0;
  assign alu_src = outOn & ctrlQ.aluSrc;
  assign ext_op  = outOn & ctrlQ.extOp;
  assign reg_dst = outOn ? ctrlQ.regDst : 2'b00;
  assign wd_sel  = outOn ? ctrlQ.wdSel : 2'b00;
  assign npc_sel = outOn ? ctrlQ.npcSel : 2'b00;
  assign lb_sel  = outOn & ctrlQ.lbSel;
  assign illegal = outOn & (stateQ == ST_DECODE) & decIll;
  assign state   = stateQ;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control vectors are
// queued as instructions are driven and compared on the falling edge.
module tb_mc_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       pcWe;
    logic       irWe;
    logic       regWe;
    logic       memWe;
    logic       memRe;
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       extOp;
    logic [1:0] regDst;
    logic [1:0] wdSel;
    logic [1:0] npcSel;
    logic       lbSel;
    logic       ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] func = 6'h00;
  logic       zero = 1'b0;
  logic       memReady = 1'b1;

  logic       pcWe, irWe, regWe, memWe, memRe, aluSrc, extOp, lbSel, ill;
  logic [2:0] aluOp, st;
  logic [1:0] regDst, wdSel, npcSel;

  logic       pcWe2, irWe2, regWe2, memWe2, memRe2, aluSrc2, extOp2, lbSel2, ill2;
  logic [2:0] aluOp2, st2;
  logic [1:0] regDst2, wdSel2, npcSel2;

  obs_t  obsNow;
  obs_t  expQ[$];
  string tagQ[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  mc_controller uDut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(memReady),
    .pc_we(pcWe), .ir_we(irWe), .reg_we(regWe), .mem_we(memWe), .mem_re(memRe),
    .alu_op(aluOp), .alu_src(aluSrc), .ext_op(extOp), .reg_dst(regDst), .wd_sel(wdSel),
    .npc_sel(npcSel), .lb_sel(lbSel), .illegal(ill), .state(st)
  );

  mc_controller #(.EXT_EN(0)) uDutNoExt (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(memReady),
    .pc_we(pcWe2), .ir_we(irWe2), .reg_we(regWe2), .mem_we(memWe2), .mem_re(memRe2),
    .alu_op(aluOp2), .alu_src(aluSrc2), .ext_op(extOp2), .reg_dst(regDst2), .wd_sel(wdSel2),
    .npc_sel(npcSel2), .lb_sel(lbSel2), .illegal(ill2), .state(st2)
  );

  assign obsNow = {st, pcWe, irWe, regWe, memWe, memRe, aluOp, aluSrc, extOp,
                   regDst, wdSel, npcSel, lbSel, ill};

  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ALU controls during WB are not part of the write-back contract, so mask them.
  always @(negedge clk) begin
    obs_t  e;
    obs_t  o;
    string t;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      o = obsNow;
      if (e.st == 3'd4) begin
        o.aluOp  = '0;
        o.aluSrc = 1'b0;
        o.extOp  = 1'b0;
      end
      checkVal(t, 32'(o), 32'(e));
    end
  end

  function automatic obs_t base(logic [2:0] s);
    obs_t e;
    e    = '0;
    e.st = s;
    return e;
  endfunction

  task automatic step(string t, obs_t e, logic [5:0] o, logic [5:0] f, logic z, logic mr);
    op       = o;
    func     = f;
    zero     = z;
    memReady = mr;
    expQ.push_back(e);
    tagQ.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(string t);
    obs_t e;
    e      = base(3'd0);
    e.irWe = 1'b1;
    e.pcWe = 1'b1;
    step({t, ".F"}, e, 6'h3f, 6'h3f, 1'b0, 1'b1);
  endtask

  task automatic runR(string t, logic [5:0] o, logic [5:0] f, logic [2:0] alu,
                      logic src, logic ext, logic [1:0] dst);
    obs_t e;
    fetch(t);
    step({t, ".D"}, base(3'd1), o, f, 1'b0, 1'b1);
    e        = base(3'd2);
    e.aluOp  = alu;
    e.aluSrc = src;
    e.extOp  = ext;
    step({t, ".E"}, e, 6'h3f, 6'h3f, 1'b1, 1'b1);
    e        = base(3'd4);
    e.regWe  = 1'b1;
    e.regDst = dst;
    step({t, ".W"}, e, 6'h3f, 6'h3f, 1'b0, 1'b1);
  endtask

  task automatic runMem(string t, logic [5:0] o, logic isLb, logic isSw, int waits);
    obs_t e;
    fetch(t);
    step({t, ".D"}, base(3'd1), o, 6'h15, 1'b0, 1'b1);
    e        = base(3'd2);
    e.aluSrc = 1'b1;
    e.extOp  = 1'b1;
    step({t, ".E"}, e, 6'h3f, 6'h3f, 1'b0, 1'b0);
    e.st    = 3'd3;
    e.memWe = isSw;
    e.memRe = !isSw;
    for (int i = 0; i < waits; i++) step($sformatf("%s.Mw%0d", t, i), e, 6'h3f, 6'h3f, 1'b0, 1'b0);
    step({t, ".M"}, e, 6'h3f, 6'h3f, 1'b0, 1'b1);
    if (!isSw) begin
      e        = base(3'd4);
      e.regWe  = 1'b1;
      e.regDst = 2'b00;
      e.wdSel  = 2'b01;
      e.lbSel  = isLb;
      step({t, ".W"}, e, 6'h3f, 6'h3f, 1'b0, 1'b1);
    end
  endtask

  task automatic runJ(string t, logic [5:0] o, logic [5:0] f, logic z, obs_t e);
    fetch(t);
    step({t, ".D"}, base(3'd1), o, f, 1'b0, 1'b1);
    step({t, ".E"}, e, 6'h3f, 6'h3f, z, 1'b1);
  endtask

  initial begin
    obs_t e;
    @(posedge clk);
    #1;
    step("reset0", '0, 6'h23, 6'h00, 1'b1, 1'b0);
    step("reset1", '0, 6'h00, 6'h21, 1'b1, 1'b1);
    reset = 1'b0;

    // jalr with the extension group removed: illegal pulse, back to FETCH in 2 cycles.
    #1;
    checkVal("noext.F.irWe", 32'(irWe2), 32'd1);
    @(posedge clk);
    #1;
    op   = 6'h00;
    func = 6'h09;
    #1;
    checkVal("noext.D.illegal", 32'(ill2), 32'd1);
    checkVal("noext.D.strobes", 32'({pcWe2, regWe2, irWe2, memWe2}), 32'd0);
    checkVal("noext.D.state", 32'(st2), 32'd1);
    checkVal("ext.D.illegal", 32'(ill), 32'd0);
    @(posedge clk);
    #1;
    checkVal("noext.back.state", 32'(st2), 32'd0);
    checkVal("noext.back.irWe", 32'(irWe2), 32'd1);
    checkVal("ext.jalr.E.pcWe", 32'(pcWe), 32'd1);
    reset = 1'b1;
    #1;
    checkVal("asyncRst.outputs", 32'(obsNow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    runR("addu", 6'h00, 6'h21, 3'd0, 1'b0, 1'b0, 2'b01);
    runR("subu", 6'h00, 6'h23, 3'd1, 1'b0, 1'b0, 2'b01);
    runR("sll",  6'h00, 6'h00, 3'd5, 1'b0, 1'b0, 2'b01);
    runR("ori",  6'h0D, 6'h2A, 3'd2, 1'b1, 1'b0, 2'b00);
    runR("lui",  6'h0F, 6'h11, 3'd4, 1'b1, 1'b0, 2'b00);

    runMem("lw3", 6'h23, 1'b0, 1'b0, 3);
    runMem("lb",  6'h20, 1'b1, 1'b0, 0);
    runMem("sw1", 6'h2B, 1'b0, 1'b1, 1);
    runMem("lw0", 6'h23, 1'b0, 1'b0, 0);

    e = base(3'd2); e.aluOp = 3'd3; e.npcSel = 2'b01; e.pcWe = 1'b1;
    runJ("beqT", 6'h04, 6'h00, 1'b1, e);
    e.pcWe = 1'b0;
    runJ("beqN", 6'h04, 6'h00, 1'b0, e);
    e = base(3'd2); e.pcWe = 1'b1; e.npcSel = 2'b10;
    runJ("j", 6'h02, 6'h00, 1'b0, e);
    e.regWe = 1'b1; e.regDst = 2'b10; e.wdSel = 2'b10;
    runJ("jal", 6'h03, 6'h00, 1'b0, e);
    e = base(3'd2); e.pcWe = 1'b1; e.npcSel = 2'b11;
    runJ("jr", 6'h00, 6'h08, 1'b0, e);
    e.regWe = 1'b1; e.regDst = 2'b01; e.wdSel = 2'b10;
    runJ("jalr", 6'h00, 6'h09, 1'b0, e);

    e = base(3'd1); e.ill = 1'b1;
    fetch("illOp");
    step("illOp.D", e, 6'h3F, 6'h00, 1'b0, 1'b1);
    fetch("illFn");
    step("illFn.D", e, 6'h00, 6'h3F, 1'b0, 1'b1);

    // sw aborted by reset while waiting in MEM.
    fetch("swAbort");
    step("swAbort.D", base(3'd1), 6'h2B, 6'h00, 1'b0, 1'b1);
    e = base(3'd2); e.aluSrc = 1'b1; e.extOp = 1'b1;
    step("swAbort.E", e, 6'h3f, 6'h3f, 1'b0, 1'b0);
    e.st = 3'd3; e.memWe = 1'b1;
    expQ.push_back(e);
    tagQ.push_back("swAbort.M");
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkVal("swAbort.memWe", 32'(memWe), 32'd0);
    checkVal("swAbort.state", 32'(st), 32'd0);
    checkVal("swAbort.outputs", 32'(obsNow), 32'd0);
    @(posedge clk);
    #1;
    checkVal("swAbort.held", 32'(obsNow), 32'd0);
    reset = 1'b0;
    runR("postRst", 6'h00, 6'h21, 3'd0, 1'b0, 1'b0, 2'b01);
    fetch("tail");

    checkVal("queueDrained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
